branch_resolve_predict: RTL
===========================

# branch_resolve_predict

Parametrised branch unit for the MIPS pipeline: resolves all conditional branch types in EX and owns a 2-bit saturating-counter pattern history table (PHT) that supplies taken predictions to IF. It raises a registered one-cycle mispredict/flush pulse with the resolved direction, and keeps saturating branch and miss counters for performance measurement. It is the sequential successor to the single-type combinational detector.

## Interface
- WIDTH, 32, operand width in bits (≥ 2)
- PHT_DEPTH, 16, number of PHT entries, power of two ≥ 2; IDX_W = log2(PHT_DEPTH)
- CNT_W, 16, width of performance counters
- clk  in  1  system clock, all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- pred_pc  in  WIDTH  PC of the instruction being fetched
- pred_taken  out  1  combinational prediction for pred_pc
- res_valid  in  1  EX stage holds a branch to resolve this cycle
- res_pc  in  WIDTH  PC of resolving branch
- res_a, res_b  in  WIDTH  register operands (rs, rt)
- res_type  in  3  0 BEQ, 1 BNE, 2 BLEZ, 3 BGTZ, 4 BLTZ, 5 BGEZ, 6 ALWAYS, 7 NEVER
- res_pred  in  1  prediction carried down the pipe for this branch
- taken_q  out  1  registered resolved direction
- mispredict_q  out  1  registered one-cycle pulse: flush younger stages
- clear_stats  in  1  synchronous clear of performance counters
- branch_cnt, miss_cnt  out  CNT_W  resolved-branch and mispredict counts

## Operation
- Index: idx(pc) = pc[IDX_W+1:2] (word-aligned); pred and res ports index independently.
- PHT entry values: 00 strong NT, 01 weak NT, 10 weak T, 11 strong T. pred_taken = entry[idx(pred_pc)][1].
- Condition (signed, two's complement, WIDTH bits): BEQ a==b; BNE a!=b; BLEZ a≤0; BGTZ a>0; BLTZ a<0; BGEZ a≥0; ALWAYS 1; NEVER 0. res_b ignored for types 2–7.
- On res_valid: taken = condition; PHT entry idx(res_pc) increments (taken) or decrements (not taken), saturating at 11/00. Types 6 and 7 also train.
- mispredict = res_valid & (taken != res_pred).
- Counters: branch_cnt +1 per res_valid; miss_cnt +1 per mispredict; both saturate at all-ones, never wrap.
- clear_stats zeroes both counters; if res_valid the same cycle, clear wins (counters read 0 next cycle); PHT unaffected.
- res_valid low: PHT, counters unchanged; taken_q holds, mispredict_q = 0.

## Timing
- Reset (async assert, any cycle, including mid-update): every PHT entry = 01, taken_q = 0, mispredict_q = 0, branch_cnt = miss_cnt = 0. pred_taken therefore 0 after reset.
- pred_taken: zero-cycle (combinational) from pred_pc and current PHT.
- Resolution latency 1 cycle: res_valid at edge N → taken_q, mispredict_q, PHT, counters updated at edge N+1 output; mispredict_q high exactly one cycle per mispredict.
- Same-index read/write: pred_pc and res_pc with equal index in the same cycle → pred_taken reflects the pre-update value; new value visible next cycle.
- Back-to-back res_valid on the same index: each cycle's update builds on the previous one (no lost updates).
- No back-pressure: one resolution accepted every cycle.

## Test plan
- Reset → pred_taken = 0 for all 16 indices; counters 0; taken_q = mispredict_q = 0.
- res_type BEQ, a=b=0x1234, res_pred=0, pc=0x40 → next cycle taken_q=1, mispredict_q=1, miss_cnt=1; pred_pc=0x40 then reads 1 (01→10).
- Signed types: a=0x8000_0000 → BLTZ taken, BGEZ not, BLEZ taken, BGTZ not; a=0 → BLEZ/BGEZ taken; BNE a=1,b=2 taken.
- Saturation: four taken updates on pc=0x8 → entry 11; one not-taken → pred still 1; two more → pred 0.
- Aliasing/collision: pc=0x4 and 0x44 (DEPTH 16) share entry; simultaneous pred_pc=res_pc index → pred_taken shows old value.
- Counters: CNT_W=4, 20 mispredicting branches → both stick at 15; clear_stats with res_valid → both 0; async rst_n mid-stream → all outputs reset immediately.

Source files
------------

// File: rtl/branch_resolve_predict.sv
// branch_resolve_predict
//   Branch unit for the MIPS pipeline. It has three jobs:
//   - Resolve conditional branches in EX (BEQ/BNE/BLEZ/BGTZ/BLTZ/BGEZ/ALWAYS/NEVER).
//   - Own a 2-bit saturating-counter pattern history table (PHT) that feeds
//     taken predictions to IF.
//   - Emit a registered one-cycle mispredict/flush pulse, and keep saturating
//     branch and miss counters.
//
// Ports
//   i_clk, i_rst_n        clock, asynchronous active-low reset
//   i_pred_pc             PC being fetched
//   o_pred_taken          combinational prediction for i_pred_pc
//   i_res_valid           EX holds a branch to resolve this cycle
//   i_res_pc              PC of the resolving branch
//   i_res_a, i_res_b      rs / rt operands (i_res_b used only by BEQ/BNE)
//   i_res_type            0 BEQ, 1 BNE, 2 BLEZ, 3 BGTZ, 4 BLTZ, 5 BGEZ,
//                         6 ALWAYS, 7 NEVER
//   i_res_pred            prediction carried down the pipe for this branch
//   o_taken_q             registered resolved direction (holds when idle)
//   o_mispredict_q        registered one-cycle flush pulse
//   i_clear_stats         synchronous clear of the performance counters
//   o_branch_cnt          saturating count of resolved branches
//   o_miss_cnt            saturating count of mispredicts
module branch_resolve_predict #(
  parameter int WIDTH     = 32,
  parameter int PHT_DEPTH = 16,
  parameter int CNT_W     = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_pred_pc,
  output logic             o_pred_taken,
  input  logic             i_res_valid,
  input  logic [WIDTH-1:0] i_res_pc,
  input  logic [WIDTH-1:0] i_res_a,
  input  logic [WIDTH-1:0] i_res_b,
  input  logic [2:0]       i_res_type,
  input  logic             i_res_pred,
  output logic             o_taken_q,
  output logic             o_mispredict_q,
  input  logic             i_clear_stats,
  output logic [CNT_W-1:0] o_branch_cnt,
  output logic [CNT_W-1:0] o_miss_cnt
);

  localparam int IDX_W = $clog2(PHT_DEPTH);

  // 2-bit counter step, saturating at 00 / 11.
  function automatic logic [1:0] pht_step(input logic [1:0] e, input logic up);
    if (up) return (e == 2'b11) ? e : e + 2'd1;
    else    return (e == 2'b00) ? e : e - 2'd1;
  endfunction

  // Performance counter increment that sticks at all-ones.
  function automatic logic [CNT_W-1:0] cnt_sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  logic [1:0]             r_pht [PHT_DEPTH];
  logic                   r_taken_p1;
  logic                   r_mispredict_p1;
  logic [CNT_W-1:0]       r_branch_cnt_p1;
  logic [CNT_W-1:0]       r_miss_cnt_p1;

  logic [IDX_W-1:0]       w_pred_idx;
  logic [IDX_W-1:0]       w_res_idx;
  logic signed [WIDTH-1:0] w_a_s;
  logic                   w_a_zero;
  logic                   w_a_neg;
  logic                   w_eq;
  logic                   w_cond_p0;
  logic                   w_mispredict_p0;
  logic                   w_unused_pc;

  // Word-aligned indexing: the low two PC bits and the bits above the
  // index never select an entry, so distinct PCs alias onto one entry.
  assign w_pred_idx  = i_pred_pc[IDX_W+1:2];
  assign w_res_idx   = i_res_pc[IDX_W+1:2];
  assign w_unused_pc = ^{i_pred_pc[WIDTH-1:IDX_W+2], i_pred_pc[1:0],
                         i_res_pc[WIDTH-1:IDX_W+2], i_res_pc[1:0]};

  // The read uses the pre-edge table contents, so a same-index
  // resolution in the same cycle is only seen by the predictor next cycle.
  assign o_pred_taken = r_pht[w_pred_idx][1];

  // ---- p0: condition evaluation (two's complement on rs) ----
  assign w_a_s    = i_res_a;
  assign w_a_zero = (i_res_a == '0);
  assign w_a_neg  = w_a_s[WIDTH-1];
  assign w_eq     = (i_res_a == i_res_b);

  always_comb begin
    w_cond_p0 = 1'b0;
    case (i_res_type)
      3'd0: w_cond_p0 = w_eq;
      3'd1: w_cond_p0 = !w_eq;
      3'd2: w_cond_p0 = w_a_neg || w_a_zero;
      3'd3: w_cond_p0 = !w_a_neg && !w_a_zero;
      3'd4: w_cond_p0 = w_a_neg;
      3'd5: w_cond_p0 = !w_a_neg;
      3'd6: w_cond_p0 = 1'b1;
      3'd7: w_cond_p0 = 1'b0;
      default: w_cond_p0 = 1'b0;
    endcase
  end

  assign w_mispredict_p0 = i_res_valid && (w_cond_p0 != i_res_pred);

  // ---- p1: registered resolution, PHT training, statistics ----
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < PHT_DEPTH; i++) r_pht[i] <= 2'b01;
      r_taken_p1      <= 1'b0;
      r_mispredict_p1 <= 1'b0;
      r_branch_cnt_p1 <= '0;
      r_miss_cnt_p1   <= '0;
    end else begin
      r_mispredict_p1 <= w_mispredict_p0;
      if (i_res_valid) begin
        r_taken_p1       <= w_cond_p0;
        r_pht[w_res_idx] <= pht_step(r_pht[w_res_idx], w_cond_p0);
      end
      // Clear takes priority over a same-cycle resolution.
      if (i_clear_stats) begin
        r_branch_cnt_p1 <= '0;
        r_miss_cnt_p1   <= '0;
      end else begin
        if (i_res_valid)     r_branch_cnt_p1 <= cnt_sat_inc(r_branch_cnt_p1);
        if (w_mispredict_p0) r_miss_cnt_p1   <= cnt_sat_inc(r_miss_cnt_p1);
      end
    end
  end

  assign o_taken_q      = r_taken_p1;
  assign o_mispredict_q = r_mispredict_p1;
  assign o_branch_cnt   = r_branch_cnt_p1;
  assign o_miss_cnt     = r_miss_cnt_p1;

endmodule
